multicycle_cu: RTL

Multi-cycle control unit that sequences the RV32I datapath (PC, instruction register, RegFile, ALU, DataRAM) through FETCH/DECODE/EXEC/MEM/WB states. It replaces the fixed single-cycle ControlUnit outputs. Each step gets its own cycle, so the PC and RegFile update only at the retire edge. DataRAM accesses wait on a ready handshake, which lets slower memories be attached later.

---
 rtl/multicycle_cu.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_cu.sv
// Multi-cycle RV32I control unit: steps the datapath through FETCH/DECODE/EXEC/MEM/WB,
// with a mem_ready handshake on DataRAM accesses and a retired-instruction counter.
module multicycle_cu (
   input  logic        clk,
   input  logic        rst,
   input  logic [6:0]  opcode,
   input  logic [2:0]  funct3,
   input  logic        funct7,
   input  logic        condition,
   input  logic        mem_ready,
   output logic        ir_we,
   output logic        pc_we,
   output logic [1:0]  pcSourceCode,
   output logic        regWe,
   output logic        memWe,
   output logic        mem_req,
   output logic [3:0]  aluOpCode,
   output logic        bIsImm,
   output logic        bIs20bImm,
   output logic        regDataIsFromMem,
   output logic        regDataIsFromPC4,
   output logic [2:0]  state,
   output logic        illegal,
   output logic [31:0] instret
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   typedef enum logic [2:0] {
      C_ALU,
      C_LOAD,
      C_STORE,
      C_BRANCH,
      C_JUMP,
      C_BAD
   } iclass_t;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   state_t  cur_state;
   state_t  next_state;
   iclass_t iclass;

   logic ir_raw;
   logic pc_raw;
   logic reg_raw;
   logic memwe_raw;
   logic req_raw;
   logic set_illegal;

   // Shared funct3 -> ALU op table for R-type and I-ALU; alt selects sub/sra.
   function automatic logic [3:0] alu_map(input logic [2:0] f3, input logic alt);
      logic [3:0] op;
      case (f3)
         3'b000:  op = alt ? 4'b0111 : 4'b0000;
         3'b001:  op = 4'b0100;
         3'b010:  op = 4'b1001;
         3'b011:  op = 4'b1100;
         3'b100:  op = 4'b0011;
         3'b101:  op = alt ? 4'b0110 : 4'b0101;
         3'b110:  op = 4'b0010;
         default: op = 4'b0001;
      endcase
      return op;
   endfunction

   // Instruction decode: datapath selects and instruction class, valid in every state.
   always_comb begin
      iclass           = C_BAD;
      aluOpCode        = 4'b0000;
      bIsImm           = 1'b0;
      bIs20bImm        = 1'b0;
      regDataIsFromMem = 1'b0;
      regDataIsFromPC4 = 1'b0;
      pcSourceCode     = 2'b00;
      case (opcode)
         OP_R: begin
            iclass    = C_ALU;
            aluOpCode = alu_map(funct3, funct7);
         end
         OP_I: begin
            iclass    = C_ALU;
            aluOpCode = alu_map(funct3, funct7 && (funct3 == 3'b101));
            bIsImm    = 1'b1;
         end
         OP_LOAD: begin
            iclass           = (funct3 == 3'b010) ? C_LOAD : C_BAD;
            bIsImm           = 1'b1;
            regDataIsFromMem = 1'b1;
         end
         OP_STORE: begin
            iclass = (funct3 == 3'b010) ? C_STORE : C_BAD;
            bIsImm = 1'b1;
         end
         OP_BRANCH: begin
            iclass       = C_BRANCH;
            pcSourceCode = condition ? 2'b01 : 2'b00;
            case (funct3)
               3'b000:  aluOpCode = 4'b1000;
               3'b100:  aluOpCode = 4'b1001;
               3'b110:  aluOpCode = 4'b1100;
               default: iclass    = C_BAD;
            endcase
         end
         OP_JAL: begin
            iclass           = C_JUMP;
            aluOpCode        = 4'b1010;
            bIsImm           = 1'b1;
            bIs20bImm        = 1'b1;
            regDataIsFromPC4 = 1'b1;
            pcSourceCode     = 2'b10;
         end
         OP_JALR: begin
            iclass           = (funct3 == 3'b000) ? C_JUMP : C_BAD;
            bIsImm           = 1'b1;
            regDataIsFromPC4 = 1'b1;
            pcSourceCode     = 2'b11;
         end
         OP_LUI: begin
            iclass    = C_ALU;
            aluOpCode = 4'b1011;
            bIsImm    = 1'b1;
            bIs20bImm = 1'b1;
         end
         default: iclass = C_BAD;
      endcase
   end

   // Next-state and enable generation.
   always_comb begin
      next_state  = cur_state;
      ir_raw      = 1'b0;
      pc_raw      = 1'b0;
      reg_raw     = 1'b0;
      memwe_raw   = 1'b0;
      req_raw     = 1'b0;
      set_illegal = 1'b0;
      case (cur_state)
         S_FETCH: begin
            ir_raw     = 1'b1;
            next_state = S_DECODE;
         end
         S_DECODE: begin
            if (iclass == C_BAD) begin
               set_illegal = 1'b1;
               next_state  = S_HALT;
            end else begin
               next_state = S_EXEC;
            end
         end
         S_EXEC: begin
            case (iclass)
               C_LOAD, C_STORE: next_state = S_MEM;
               C_BRANCH: begin
                  pc_raw     = 1'b1;
                  next_state = S_FETCH;
               end
               C_JUMP: begin
                  pc_raw     = 1'b1;
                  reg_raw    = 1'b1;
                  next_state = S_FETCH;
               end
               default: next_state = S_WB;
            endcase
         end
         S_MEM: begin
            req_raw   = 1'b1;
            memwe_raw = (iclass == C_STORE);
            if (mem_ready) begin
               if (iclass == C_STORE) begin
                  pc_raw     = 1'b1;
                  next_state = S_FETCH;
               end else begin
                  next_state = S_WB;
               end
            end
         end
         S_WB: begin
            reg_raw    = 1'b1;
            pc_raw     = 1'b1;
            next_state = S_FETCH;
         end
         default: next_state = S_HALT;
      endcase
   end

   // No write may fire while reset is being applied, whatever state we were in.
   assign ir_we   = ir_raw    & ~rst;
   assign pc_we   = pc_raw    & ~rst;
   assign regWe   = reg_raw   & ~rst;
   assign memWe   = memwe_raw & ~rst;
   assign mem_req = req_raw   & ~rst;
   assign state   = cur_state;

   always_ff @(posedge clk) begin
      if (rst) begin
         cur_state <= S_FETCH;
         illegal   <= 1'b0;
         instret   <= 32'd0;
      end else begin
         cur_state <= next_state;
         if (set_illegal) illegal <= 1'b1;
         if (pc_we) instret <= instret + 32'd1;
      end
   end

endmodule
